// File: rtl/accel_spi_reader.sv
// accel_spi_reader
//   SPI master (mode 3, 4-wire) for an ADXL345 accelerometer. After reset it
//   writes DATA_FORMAT (0x31 <- 0x0B) and POWER_CTL (0x2D <- 0x08), then bursts
//   the six data registers (0x32..0x37) once every SAMPLE_PERIOD clocks and
//   presents X/Y/Z as three registered words that update together.
//
// Parameters
//   CLK_DIV        SCLK half-period in clk cycles (>= 2)
//   SAMPLE_PERIOD  clk cycles from one read's CS fall to the next (>= 120*CLK_DIV)
//
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   spi_sclk/cs_n/mosi    SPI master outputs (SCLK idles high, CS active low)
//   spi_miso              SPI slave data in (already synchronised)
//   accel_x/y/z           last complete sample, two's complement
//   sample_valid          one-cycle pulse on the cycle accel_* update
//   init_done             high once the sensor has been configured
//   sample_count          number of completed reads, wraps at 16 bits
module accel_spi_reader #(
  parameter int CLK_DIV       = 25,
  parameter int SAMPLE_PERIOD = 500000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        spi_sclk,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic [15:0] accel_x,
  output logic [15:0] accel_y,
  output logic [15:0] accel_z,
  output logic        sample_valid,
  output logic        init_done,
  output logic [15:0] sample_count
);

  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int WAIT_W = $clog2(SAMPLE_PERIOD);

  localparam logic [DIV_W-1:0]  DIV_LAST    = DIV_W'(CLK_DIV - 1);
  localparam logic [WAIT_W-1:0] GAP_LOAD    = WAIT_W'(2 * CLK_DIV - 1);
  localparam logic [WAIT_W-1:0] PERIOD_LOAD = WAIT_W'(SAMPLE_PERIOD - 1);

  // Transmit words are MSB-aligned in a 56-bit shifter; unused tail is zero so
  // MOSI naturally returns to 0 once the meaningful bytes have shifted out.
  localparam logic [55:0] FMT_WORD  = {8'h31, 8'h0B, 40'h0};
  localparam logic [55:0] PWR_WORD  = {8'h2D, 8'h08, 40'h0};
  localparam logic [55:0] READ_WORD = {8'hF2, 48'h0};
  localparam logic [5:0]  WR_LAST_BIT = 6'd15;
  localparam logic [5:0]  RD_LAST_BIT = 6'd55;

  typedef enum logic [2:0] {INIT_FMT, GAP1, INIT_PWR, WAIT, READ} state_t;
  typedef enum logic [2:0] {PH_IDLE, PH_SETUP, PH_LOW, PH_HIGH, PH_HOLD} phase_t;

  state_t              state_reg, state_next;
  phase_t              phase_reg;
  logic [DIV_W-1:0]    div_cnt_reg;
  logic [5:0]          bit_cnt_reg;
  logic [5:0]          last_bit_reg;
  logic [55:0]         tx_reg;
  logic [47:0]         rx_reg;
  logic [WAIT_W-1:0]   wait_cnt_reg;
  logic                sclk_reg;
  logic                cs_n_reg;
  logic                sample_valid_reg;
  logic                init_done_reg;
  logic [15:0]         sample_count_reg;

  logic                div_end;
  logic                xfer_done;
  logic                load_sample;
  logic                start_xfer;
  logic [55:0]         start_word;
  logic [5:0]          start_last;
  logic                wait_load;
  logic [WAIT_W-1:0]   wait_value;

  assign div_end     = (phase_reg != PH_IDLE) && (div_cnt_reg == DIV_LAST);
  assign xfer_done   = (phase_reg == PH_HOLD) && div_end;
  assign load_sample = (state_reg == READ) && xfer_done;

  // ---------------------------------------------------------------------------
  // Sequencer. Transactions are launched on the same edge the gap/period
  // counter expires, so CS falls exactly on the counted cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state_reg <= INIT_FMT;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    start_xfer = 1'b0;
    start_word = '0;
    start_last = WR_LAST_BIT;
    wait_load  = 1'b0;
    wait_value = GAP_LOAD;
    case (state_reg)
      INIT_FMT: begin
        if (phase_reg == PH_IDLE) begin
          start_xfer = 1'b1;
          start_word = FMT_WORD;
        end else if (xfer_done) begin
          state_next = GAP1;
          wait_load  = 1'b1;
        end
      end
      GAP1: begin
        if (wait_cnt_reg == '0) begin
          start_xfer = 1'b1;
          start_word = PWR_WORD;
          state_next = INIT_PWR;
        end
      end
      INIT_PWR: begin
        if (xfer_done) begin
          state_next = WAIT;
          wait_load  = 1'b1;
        end
      end
      WAIT: begin
        if (wait_cnt_reg == '0) begin
          start_xfer = 1'b1;
          start_word = READ_WORD;
          start_last = RD_LAST_BIT;
          wait_load  = 1'b1;
          wait_value = PERIOD_LOAD;
          state_next = READ;
        end
      end
      READ: begin
        if (xfer_done) state_next = WAIT;
      end
      default: state_next = INIT_FMT;
    endcase
  end

  // Gap / period counter. It is reloaded at each read start and keeps running
  // through the read, so the CS-fall-to-CS-fall period never slips.
  always_ff @(posedge clk) begin
    if (reset)                   wait_cnt_reg <= '0;
    else if (wait_load)          wait_cnt_reg <= wait_value;
    else if (wait_cnt_reg != '0) wait_cnt_reg <= wait_cnt_reg - WAIT_W'(1);
  end

  // ---------------------------------------------------------------------------
  // Transaction engine: SETUP (SCLK high, first bit out), then LOW/HIGH pairs
  // per bit, then HOLD before CS is released.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_reg    <= PH_IDLE;
      div_cnt_reg  <= '0;
      bit_cnt_reg  <= '0;
      last_bit_reg <= WR_LAST_BIT;
      tx_reg       <= '0;
      rx_reg       <= '0;
      sclk_reg     <= 1'b1;
      cs_n_reg     <= 1'b1;
    end else if (start_xfer) begin
      phase_reg    <= PH_SETUP;
      div_cnt_reg  <= '0;
      bit_cnt_reg  <= '0;
      last_bit_reg <= start_last;
      tx_reg       <= start_word;
      sclk_reg     <= 1'b1;
      cs_n_reg     <= 1'b0;
    end else if (phase_reg != PH_IDLE) begin
      div_cnt_reg <= div_end ? '0 : div_cnt_reg + DIV_W'(1);
      if (div_end) begin
        case (phase_reg)
          PH_SETUP: begin
            // First falling edge: MOSI already carries bit 7, so no shift here.
            phase_reg <= PH_LOW;
            sclk_reg  <= 1'b0;
          end
          PH_LOW: begin
            phase_reg <= PH_HIGH;
            sclk_reg  <= 1'b1;
            rx_reg    <= {rx_reg[46:0], spi_miso};
          end
          PH_HIGH: begin
            if (bit_cnt_reg == last_bit_reg) begin
              phase_reg <= PH_HOLD;
            end else begin
              phase_reg   <= PH_LOW;
              sclk_reg    <= 1'b0;
              bit_cnt_reg <= bit_cnt_reg + 6'd1;
              tx_reg      <= {tx_reg[54:0], 1'b0};
            end
          end
          PH_HOLD: begin
            phase_reg <= PH_IDLE;
            cs_n_reg  <= 1'b1;
            tx_reg    <= '0;
          end
          default: phase_reg <= PH_IDLE;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sample outputs. Burst bytes arrive X0 X1 Y0 Y1 Z0 Z1; axis gi's low byte is
  // burst byte 2*gi+1, high byte 2*gi+2. All three load on the CS-rise cycle.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 3; gi++) begin : g_axis
    logic [15:0] word_reg;
    always_ff @(posedge clk) begin
      if (reset)            word_reg <= '0;
      else if (load_sample) word_reg <= {rx_reg[39-16*gi -: 8], rx_reg[47-16*gi -: 8]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sample_valid_reg <= 1'b0;
      init_done_reg    <= 1'b0;
    end else begin
      sample_valid_reg <= load_sample;
      if ((state_reg == INIT_PWR) && xfer_done) init_done_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)            sample_count_reg <= '0;
    else if (load_sample) sample_count_reg <= sample_count_reg + 16'd1;
  end

  assign spi_sclk     = sclk_reg;
  assign spi_cs_n     = cs_n_reg;
  assign spi_mosi     = tx_reg[55];
  assign accel_x      = g_axis[0].word_reg;
  assign accel_y      = g_axis[1].word_reg;
  assign accel_z      = g_axis[2].word_reg;
  assign sample_valid = sample_valid_reg;
  assign init_done    = init_done_reg;
  assign sample_count = sample_count_reg;

endmodule
